// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and status bundle for the synchronous FIFO
package sync_fifo_pkg;
  localparam int DEFAULT_DSIZE = 8;
  localparam int DEFAULT_ASIZE = 4;
  typedef struct packed {
    logic wfull;
    logic rempty;
    logic walmost_full;
    logic ralmost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DSIZE storage, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem_q [2**ASIZE];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count-decoded flags and sticky over/underflow
// SYNC_FIFO_FWFT_EN selects first-word fall-through rdata; otherwise rdata is registered on pop.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DSIZE    = DEFAULT_DSIZE,
  parameter int ASIZE    = DEFAULT_ASIZE,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [ASIZE:0] FULL_N = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AF_N = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_N = (ASIZE+1)'(AE_LEVEL);
  logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ASIZE:0] count_q, count_d;
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  logic wr_ok, rd_ok;
  logic [DSIZE-1:0] head;
  fifo_status_t st;
  fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk(clk), .we(wr_ok && !rst), .waddr(wptr_q), .wdata(wdata), .raddr(rptr_q), .rdata(head)
  );
  assign st = '{wfull: count_q == FULL_N, rempty: count_q == '0,
                walmost_full: count_q >= AF_N, ralmost_empty: count_q <= AE_N,
                overflow: overflow_q, underflow: underflow_q};
  assign wr_ok = winc && !st.wfull;
  assign rd_ok = rinc && !st.rempty;
  always_comb begin
    wptr_d = rst ? '0 : wptr_q + ASIZE'(wr_ok);
    rptr_d = rst ? '0 : rptr_q + ASIZE'(rd_ok);
    count_d = rst ? '0 : count_q + (ASIZE+1)'(wr_ok) - (ASIZE+1)'(rd_ok);
    overflow_d = !rst && (overflow_q || (winc && st.wfull));
    underflow_d = !rst && (underflow_q || (rinc && st.rempty));
  end
  always_ff @(posedge clk) begin
    wptr_q <= wptr_d;
    rptr_q <= rptr_d;
    count_q <= count_d;
    overflow_q <= overflow_d;
    underflow_q <= underflow_d;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = st.rempty ? '0 : head;
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;
  assign rdata_d = rst ? '0 : rd_ok ? head : rdata_q;
  always_ff @(posedge clk) rdata_q <= rdata_d;
  assign rdata = rdata_q;
`endif
  assign wfull = st.wfull;
  assign rempty = st.rempty;
  assign walmost_full = st.walmost_full;
  assign ralmost_empty = st.ralmost_empty;
  assign overflow = st.overflow;
  assign underflow = st.underflow;
  assign count = count_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (DSIZE=8, ASIZE=4)
module tb_sync_fifo_param;
  logic clk = 0, rst = 1, winc = 0, rinc = 0;
  logic [7:0] wdata = 0, rdata;
  logic wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0] count;
  int n_chk = 0, n_fail = 0;
  sync_fifo_param #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
    .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic rs, input logic w, input logic [7:0] d, input logic r);
    rst = rs; winc = w; wdata = d; rinc = r;
    @(posedge clk); #1;
    rst = 0; winc = 0; rinc = 0;
  endtask
  task automatic test_reset;
    cyc(1, 0, 0, 0);
    n_chk++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_chk++; if ({wfull, rempty, walmost_full, ralmost_empty, overflow, underflow} !== 6'b010100) begin
      n_fail++; $display("FAIL reset_flags got %b exp 010100", {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow}); end
    n_chk++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata got %h exp 00", rdata); end
  endtask
  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 8'(i), 0);
      n_chk++; if (count !== 5'(i + 1) || walmost_full !== (i + 1 >= 12) || ralmost_empty !== (i + 1 <= 4)) begin
        n_fail++; $display("FAIL fill_%0d count=%0d af=%b ae=%b exp count=%0d af=%b ae=%b", i, count, walmost_full, ralmost_empty, i + 1, i + 1 >= 12, i + 1 <= 4); end
    end
    n_chk++; if (wfull !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL fill_full wfull=%b ovf=%b exp 1 0", wfull, overflow); end
    cyc(0, 1, 8'hFF, 0);
    n_chk++; if (overflow !== 1'b1 || count !== 5'd16) begin n_fail++; $display("FAIL fill_overflow ovf=%b count=%0d exp 1 16", overflow, count); end
  endtask
  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      n_chk++; if (rdata !== 8'(i)) begin n_fail++; $display("FAIL drain_%0d got %h exp %h", i, rdata, 8'(i)); end
      cyc(0, 0, 0, 1);
`else
      cyc(0, 0, 0, 1);
      n_chk++; if (rdata !== 8'(i)) begin n_fail++; $display("FAIL drain_%0d got %h exp %h", i, rdata, 8'(i)); end
`endif
    end
    n_chk++; if (rempty !== 1'b1 || count !== 5'd0 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty rempty=%b count=%0d ovf=%b exp 1 0 1", rempty, count, overflow); end
    cyc(0, 0, 0, 1);
`ifdef SYNC_FIFO_FWFT_EN
    n_chk++; if (underflow !== 1'b1 || rdata !== 8'h00) begin n_fail++; $display("FAIL drain_underflow unf=%b rdata=%h exp 1 00", underflow, rdata); end
`else
    n_chk++; if (underflow !== 1'b1 || rdata !== 8'h0F) begin n_fail++; $display("FAIL drain_underflow unf=%b rdata=%h exp 1 0f", underflow, rdata); end
`endif
  endtask
  task automatic test_wrap;
    logic [7:0] nw, nr;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 8'(i), 0);
    nw = 5; nr = 0;
    for (int k = 0; k < 40; k++) begin
      if ((k / 5) % 2 == 0) begin
        cyc(0, 1, nw, 0); nw++;
      end else begin
`ifdef SYNC_FIFO_FWFT_EN
        n_chk++; if (rdata !== nr) begin n_fail++; $display("FAIL wrap_%0d got %h exp %h", k, rdata, nr); end
        cyc(0, 0, 0, 1);
`else
        cyc(0, 0, 0, 1);
        n_chk++; if (rdata !== nr) begin n_fail++; $display("FAIL wrap_%0d got %h exp %h", k, rdata, nr); end
`endif
        nr++;
      end
    end
    n_chk++; if (count !== 5'd5) begin n_fail++; $display("FAIL wrap_count got %0d exp 5", count); end
  endtask
  task automatic test_simul;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 8'(8'h40 + i), 0);
    cyc(0, 1, 8'hEE, 1);
    n_chk++; if (count !== 5'd15 || overflow !== 1'b1 || wfull !== 1'b0) begin
      n_fail++; $display("FAIL simul_full count=%0d ovf=%b wfull=%b exp 15 1 0", count, overflow, wfull); end
`ifdef SYNC_FIFO_FWFT_EN
    n_chk++; if (rdata !== 8'h41) begin n_fail++; $display("FAIL simul_full_rdata got %h exp 41", rdata); end
`else
    n_chk++; if (rdata !== 8'h40) begin n_fail++; $display("FAIL simul_full_rdata got %h exp 40", rdata); end
`endif
    cyc(1, 0, 0, 0);
    cyc(0, 1, 8'h77, 1);
    n_chk++; if (count !== 5'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL simul_empty count=%0d unf=%b ovf=%b exp 1 1 0", count, underflow, overflow); end
    cyc(0, 0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
    n_chk++; if (rdata !== 8'h77) begin n_fail++; $display("FAIL simul_empty_rdata got %h exp 77", rdata); end
`endif
    n_chk++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL simul_empty_pop rempty=%b exp 1", rempty); end
  endtask
  task automatic test_reset_mid;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 9; i++) cyc(0, 1, 8'(8'h10 + i), 0);
    n_chk++; if (count !== 5'd9 || underflow !== 1'b1) begin n_fail++; $display("FAIL mid_pre count=%0d unf=%b exp 9 1", count, underflow); end
    cyc(1, 1, 8'h99, 0);
    n_chk++; if (count !== 5'd0 || {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow} !== 6'b010100) begin
      n_fail++; $display("FAIL mid_reset count=%0d flags=%b exp 0 010100", count, {wfull, rempty, walmost_full, ralmost_empty, overflow, underflow}); end
    cyc(0, 1, 8'hA5, 0);
`ifdef SYNC_FIFO_FWFT_EN
    n_chk++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL mid_readback got %h exp a5", rdata); end
    cyc(0, 0, 0, 1);
`else
    cyc(0, 0, 0, 1);
    n_chk++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL mid_readback got %h exp a5", rdata); end
`endif
  endtask
  task automatic test_fwft;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 8'h3C, 0);
`ifdef SYNC_FIFO_FWFT_EN
    n_chk++; if (rdata !== 8'h3C) begin n_fail++; $display("FAIL fwft_head got %h exp 3c", rdata); end
`else
    n_chk++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL fwft_head got %h exp 00", rdata); end
    cyc(0, 0, 0, 0);
    n_chk++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL fwft_idle got %h exp 00", rdata); end
`endif
    cyc(0, 0, 0, 1);
`ifdef SYNC_FIFO_FWFT_EN
    n_chk++; if (rdata !== 8'h00 || rempty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop rdata=%h rempty=%b exp 00 1", rdata, rempty); end
`else
    n_chk++; if (rdata !== 8'h3C || rempty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop rdata=%h rempty=%b exp 3c 1", rdata, rempty); end
`endif
  endtask
  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_wrap;
    test_simul;
    test_reset_mid;
    test_fwft;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
